// File: rtl/prefix_adder_pkg.sv
// Shared constants for the pipelined parallel-prefix adder: operation
// encodings and the bit positions of the {N,Z,C,V} flags.
package prefix_adder_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/prefix_adder_pipe_cell.sv
// Black cell of the prefix tree: merges a high group (Gh,Ph) with the
// adjacent lower group (Gl,Pl) into one wider generate/propagate group.
module prefix_pg_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Define PREFIX_ADDER_FLAGS_EN to build the {N,Z,C,V} flag path; otherwise flags are tied to 0.
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);

    localparam int LOG = $clog2(WIDTH);
    localparam int NL  = LOG + 1;

    // Internal bank k sits after level ((k+1)*NL)/STAGES - 1; never after the last level.
    function automatic int bank_after(input int lvl);
        int bank = -1;
        for (int k = 0; k < STAGES - 1; k++) begin
            if (((k + 1) * NL) / STAGES - 1 == lvl) bank = k;
        end
        return bank;
    endfunction

    logic [STAGES-1:0] valid_q, valid_d, load, cap;
    logic [STAGES:0]   chain_v;

    assign chain_v = {valid_q, in_valid};

    // A stage loads unless it and every stage after it are full with the output blocked.
    always_comb begin
        load    = '0;
        cap     = '0;
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            load[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j]) load[k] = 1'b1;
            end
            cap[k] = load[k] & chain_v[k];
            if (load[k]) valid_d[k] = chain_v[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];

    logic [WIDTH-1:0] b_eff;
    logic             c_in;

    always_comb begin
        b_eff = b;
        c_in  = 1'b0;
        case (op)
            OP_ADD:  begin b_eff = b;  c_in = 1'b0; end
            OP_ADC:  begin b_eff = b;  c_in = cin;  end
            OP_SUB:  begin b_eff = ~b; c_in = 1'b1; end
            OP_SBC:  begin b_eff = ~b; c_in = cin;  end
            default: begin b_eff = b;  c_in = 1'b0; end
        endcase
    end

    // Level outputs (g_o..) and the values feeding the next level (g_s..), registered or not.
    logic [WIDTH-1:0] g_o [NL];
    logic [WIDTH-1:0] p_o [NL];
    logic [WIDTH-1:0] x_o [NL];
    logic             c_o [NL];
    logic [WIDTH-1:0] g_s [NL];
    logic [WIDTH-1:0] p_s [NL];
    logic [WIDTH-1:0] x_s [NL];
    logic             c_s [NL];

    for (genvar l = 0; l < NL; l++) begin : g_level
        if (l == 0) begin : g_bitwise
            logic [WIDTH-1:0] g_raw, p_raw;
            logic             g_fold, p_fold;
            assign g_raw = a & b_eff;
            assign p_raw = a | b_eff;
            prefix_pg_cell u_cin_cell (
                .g_hi  (g_raw[0]),
                .p_hi  (p_raw[0]),
                .g_lo  (c_in),
                .p_lo  (1'b0),
                .g_out (g_fold),
                .p_out (p_fold)
            );
            assign g_o[0] = {g_raw[WIDTH-1:1], g_fold};
            assign p_o[0] = {p_raw[WIDTH-1:1], p_fold};
            assign x_o[0] = a ^ b_eff;
            assign c_o[0] = c_in;
        end else begin : g_prefix
            localparam int D = 1 << (l - 1);
            logic [WIDTH-1:0] g_n, p_n;
            for (genvar i = 0; i < WIDTH; i++) begin : g_node
                if (i >= D) begin : g_black
                    prefix_pg_cell u_cell (
                        .g_hi  (g_s[l-1][i]),
                        .p_hi  (p_s[l-1][i]),
                        .g_lo  (g_s[l-1][i-D]),
                        .p_lo  (p_s[l-1][i-D]),
                        .g_out (g_n[i]),
                        .p_out (p_n[i])
                    );
                end else begin : g_pass
                    assign g_n[i] = g_s[l-1][i];
                    assign p_n[i] = p_s[l-1][i];
                end
            end
            assign g_o[l] = g_n;
            assign p_o[l] = p_n;
            assign x_o[l] = x_s[l-1];
            assign c_o[l] = c_s[l-1];
        end
    end

    for (genvar l = 0; l < NL; l++) begin : g_cut
        localparam int BK = bank_after(l);
        if (BK >= 0) begin : g_bank
            logic [WIDTH-1:0] g_q, g_d, p_q, p_d, x_q, x_d;
            logic             c_q, c_d;

            always_comb begin
                g_d = g_q;
                p_d = p_q;
                x_d = x_q;
                c_d = c_q;
                if (cap[BK]) begin
                    g_d = g_o[l];
                    p_d = p_o[l];
                    x_d = x_o[l];
                    c_d = c_o[l];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    g_q <= '0;
                    p_q <= '0;
                    x_q <= '0;
                    c_q <= 1'b0;
                end else begin
                    g_q <= g_d;
                    p_q <= p_d;
                    x_q <= x_d;
                    c_q <= c_d;
                end
            end

            assign g_s[l] = g_q;
            assign p_s[l] = p_q;
            assign x_s[l] = x_q;
            assign c_s[l] = c_q;
        end else begin : g_wire
            assign g_s[l] = g_o[l];
            assign p_s[l] = p_o[l];
            assign x_s[l] = x_o[l];
            assign c_s[l] = c_o[l];
        end
    end

    // Carry into bit i is the group generate of bits i-1 down to the carry-in.
    logic [WIDTH-1:0] carry, sum_new, sum_d, sum_q;

    always_comb begin
        carry   = {g_s[LOG][WIDTH-2:0], c_s[LOG]};
        sum_new = x_s[LOG] ^ carry;
        sum_d   = sum_q;
        if (cap[STAGES-1]) sum_d = sum_new;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign sum = sum_q;

`ifdef PREFIX_ADDER_FLAGS_EN
    logic [3:0] flags_new, flags_d, flags_q;

    always_comb begin
        flags_new         = '0;
        flags_new[FLAG_N] = sum_new[WIDTH-1];
        flags_new[FLAG_Z] = ~|sum_new;
        flags_new[FLAG_C] = g_s[LOG][WIDTH-1];
        flags_new[FLAG_V] = carry[WIDTH-1] ^ g_s[LOG][WIDTH-1];
        flags_d           = flags_q;
        if (cap[STAGES-1]) flags_d = flags_new;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flags_q <= '0;
        else          flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe (WIDTH=32, STAGES=2): vector table,
// back-to-back stream with a mid-stream stall, and reset with beats in flight.
module tb_prefix_adder_pipe;
    import prefix_adder_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
`ifdef PREFIX_ADDER_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [1:0]  op;
        logic [31:0] sum;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[15];

    prefix_adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                                input logic [1:0] vo, input logic [31:0] vs, input logic [3:0] vf);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.op = vo; v.sum = vs; v.flags = vf;
        return v;
    endfunction

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drives one beat with out_ready=1, scrambles inputs after accept, returns edges to out_valid.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                                 input logic [1:0] to, output int lat);
        int guard;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ta; b = tbv; cin = tc; op = to;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = ta ^ tbv; cin = ~tc; op = ~to;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic runStream();
        logic [31:0] sa[8], sb[8], se[8];
        logic [31:0] prev_sum;
        bit          stalled_prev, ready_fell, accepted;
        int          sent, recv, cyc;
        for (int i = 0; i < 8; i++) begin
            sa[i] = 32'h1111_1111 * (i + 1) + 32'hF000_0000;
            sb[i] = 32'h0F0F_0F0F + 32'h0000_0100 * i;
            se[i] = sa[i] + sb[i];
        end
        sent = 0; recv = 0; cyc = 0;
        stalled_prev = 1'b0; ready_fell = 1'b0; prev_sum = '0;
        while (recv < 8 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = (sent < 8);
            cin = 1'b0; op = OP_ADD;
            if (sent < 8) begin a = sa[sent]; b = sb[sent]; end
            #1;
            if (stalled_prev) begin
                checkOutput($sformatf("stall_hold_sum_c%0d", cyc), sum, prev_sum);
                checkOutput($sformatf("stall_hold_valid_c%0d", cyc), out_valid, 1);
            end
            if (in_valid && !in_ready) ready_fell = 1'b1;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream_sum_%0d", recv), sum, se[recv]);
                recv++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_sum     = sum;
            accepted     = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_count", recv, 8);
        checkOutput("stream_ready_fell", ready_fell, 1);
        #1;
        checkOutput("stream_drain", out_valid, 0);
    endtask

    task automatic runResetFlight();
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cin = 1'b0; op = OP_ADD;
        a = 32'h0000_00AA; b = 32'h0000_0011;
        @(posedge clk); #1;
        a = 32'h0000_00BB; b = 32'h0000_0022;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("flight_valid_before_reset", out_valid, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("flight_reset_out_valid", out_valid, 0);
        checkOutput("flight_reset_sum", sum, 0);
        checkOutput("flight_reset_flags", flags, 0);
        checkOutput("flight_reset_in_ready", in_ready, 1);
        in_valid = 1'b1;
        a = 32'h0000_0CCC; b = 32'h0000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("flight_no_ghost_%0d", i), out_valid, 0);
        end
        applyStimulus(32'h0000_1234, 32'h0000_4321, 1'b0, OP_ADD, lat);
        checkOutput("post_reset_latency", lat, STAGES);
        checkOutput("post_reset_sum", sum, 32'h0000_5555);
    endtask

    initial begin
        int lat;
        vecs[0]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0000, 4'b0110);
        vecs[1]  = mk(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 4'b0011);
        vecs[2]  = mk(32'h0000_0005, 32'h0000_0005, 1'b0, OP_SBC, 32'hFFFF_FFFF, 4'b1000);
        vecs[3]  = mk(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, OP_ADC, 32'h8000_0000, 4'b1001);
        vecs[4]  = mk(32'h0000_0001, 32'h0000_0002, 1'b0, OP_ADD, 32'h0000_0003, 4'b0000);
        vecs[5]  = mk(32'h0000_0001, 32'h0000_0001, 1'b1, OP_ADD, 32'h0000_0002, 4'b0000);
        vecs[6]  = mk(32'h0000_0005, 32'h0000_0005, 1'b0, OP_SUB, 32'h0000_0000, 4'b0110);
        vecs[7]  = mk(32'h0000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'hFFFF_FFFF, 4'b1000);
        vecs[8]  = mk(32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, 32'h0000_0000, 4'b0111);
        vecs[9]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, OP_ADC, 32'hFFFF_FFFF, 4'b1010);
        vecs[10] = mk(32'h0000_000A, 32'h0000_0003, 1'b1, OP_SBC, 32'h0000_0007, 4'b0010);
        vecs[11] = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, OP_SUB, 32'h8000_0000, 4'b1001);
        vecs[12] = mk(32'h1234_5678, 32'h8765_4321, 1'b0, OP_ADD, 32'h9999_9999, 4'b1000);
        vecs[13] = mk(32'h0000_0000, 32'h0000_0000, 1'b0, OP_ADC, 32'h0000_0000, 4'b0100);
        vecs[14] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, OP_SBC, 32'h0000_0000, 4'b0110);

        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op = OP_ADD;
        #2;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_flags", flags, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, STAGES);
            checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            checkOutput($sformatf("vec%0d_flags", i), flags, FLAGS_ON ? vecs[i].flags : 4'b0000);
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_no_dup", i), out_valid, 0);
        end

        runStream();
        runResetFlight();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/prefix_adder_pipe.md
PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 Parameter: WIDTH, 32, operand width; legal values are powers of two, 8..64.
REQ-002 Parameter: STAGES, 2, register stages; legal range is 1..log2(WIDTH)+1.
REQ-003 Port: clk  input  1  single clock; all registers sample on the rising edge.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  operand beat present.
REQ-006 Port: in_ready  output  1  adder accepts the beat this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: cin  input  1  carry input, used by ADC and SBC.
REQ-010 Port: op  input  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBC.
REQ-011 Port: out_valid  output  1  result beat present.
REQ-012 Port: out_ready  input  1  downstream accepts the result beat.
REQ-013 Port: sum  output  WIDTH  result.
REQ-014 Port: flags  output  4  {N,Z,C,V}.
REQ-015 Reset is asynchronous and active-low on reset_n; there is one clock, clk.

Function
REQ-016 Effective operands SHALL be:
- ADD: b, carry-in 0.
- ADC: b, carry-in cin.
- SUB: ~b, carry-in 1.
- SBC: ~b, carry-in cin.
REQ-017 The carry tree SHALL be a parallel-prefix network:
- log2(WIDTH)+1 levels; level 0 is bitwise G=a&b', P=a|b' with carry-in folded in as bit -1.
- sum[i] = a[i]^b'[i]^G[i-1:-1].
REQ-018 Pipeline registers SHALL be distributed evenly across prefix levels:
- STAGES register banks in total; the last bank is at the output.
- Latency from the accept cycle to out_valid is exactly STAGES cycles with no stall.
REQ-019 Each stage SHALL hold a valid bit and SHALL load when it is empty or the next stage loads that cycle; the output stage loads when it is empty or out_ready=1.
REQ-020 in_ready SHALL equal the stage-0 load condition; a beat is accepted iff in_valid and in_ready are both 1.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1; bubbles SHALL collapse under backpressure; no beat is dropped or duplicated.
REQ-022 While out_valid=1 and out_ready=0, sum and flags SHALL hold stable.
REQ-023 C SHALL be the carry-out of bit WIDTH-1; for SUB and SBC, C=1 means no borrow (ARM convention).
REQ-024 V SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-025 N SHALL be sum[WIDTH-1].
REQ-026 Z SHALL be 1 iff sum is all zero.
REQ-027 Operands and op SHALL be captured at accept; later input changes do not affect beats in flight.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear every stage valid bit, so out_valid=0.
REQ-029 During reset, sum and flags SHALL be 0.
REQ-030 During reset, in_ready SHALL be 1; beats are not accepted while reset_n=0.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; the first beat accepted after deassertion emerges after STAGES cycles.

Configuration
REQ-032 PREFIX_ADDER_FLAGS_EN defined: flags SHALL be computed per REQ-023 to REQ-026 and pipelined alongside sum.
REQ-033 PREFIX_ADDER_FLAGS_EN undefined: flags SHALL be tied to 0 and no flag logic or registers SHALL be generated; sum and handshake behaviour SHALL be unchanged.

Structure
REQ-034 Shared package prefix_adder_pkg SHALL hold:
- the op encoding constants (OP_ADD, OP_ADC, OP_SUB, OP_SBC);
- the flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
REQ-035 One sub-module, prefix_pg_cell, SHALL implement the black cell: G = Gh|(Ph&Gl), P = Ph&Pl; all tree nodes instantiate it.

Verification (WIDTH=32, STAGES=2, flags enabled)
REQ-036 Scenario: ADD a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, flags=0110, out_valid 2 cycles after accept.
REQ-037 Scenario: SUB a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, flags=0011.
REQ-038 Scenario: SBC a=5, b=5, cin=0 -> sum=0xFFFFFFFF, flags=1000.
REQ-039 Scenario: ADC a=0x7FFFFFFF, b=0, cin=1 -> sum=0x80000000, flags=1001.
REQ-040 Scenario: stream 8 beats back-to-back, hold out_ready=0 for 4 cycles mid-stream ->
- in_ready falls once the pipe is full;
- all 8 results arrive in order, none lost or duplicated;
- sum is stable while stalled.
REQ-041 Scenario: assert reset_n low with 2 beats in flight -> out_valid=0 immediately, those beats never appear; the next beat appears 2 cycles after its accept.
